// File: rtl/uart_dtm_ctrl.sv
// UART DTM frame sequencer: header/command/payload parsing, IDCODE/DTMCS/DMI access, read-back.
// Optional inter-byte timeout in CMD/RX is enabled by defining UART_DTM_TIMEOUT_EN.
module uart_dtm_ctrl #(
    parameter logic [31:0] IDCODE         = 32'h00000001,
    parameter logic [2:0]  IDLE_HINT      = 3'd1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic        dmi_hardreset_o
);

    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_RW    = 3'd3;
    localparam logic [2:0] CMD_RESET = 3'd4;
    localparam logic [4:0] ADDR_IDCODE = 5'h01;
    localparam logic [4:0] ADDR_DTMCS  = 5'h10;
    localparam logic [4:0] ADDR_DMI    = 5'h11;

    typedef enum logic [2:0] {StIdle, StCmd, StRx, StReq, StWait, StTx} state_e;

    state_e      r_state;
    logic        r_rw;
    logic [4:0]  r_addr;
    logic [40:0] r_payload;
    logic [2:0]  r_cnt;
    logic [1:0]  r_dmistat;
    logic [33:0] r_result;
    logic [39:0] r_tx_shift;
    logic [2:0]  r_tx_left;
    logic        r_rx_ready;
    logic        r_tx_valid;
    logic [40:0] r_dmi_req;
    logic        r_dmi_req_valid;
    logic        r_dmi_resp_ready;
    logic        r_hardreset;

    logic        w_rx_fire, w_tx_fire, w_req_fire, w_resp_fire;
    logic [2:0]  w_cmd;
    logic [4:0]  w_addr;
    logic [47:0] w_payload;
    logic        w_last;
    logic [1:0]  w_stat_after_rx;
    logic [4:0]  w_load_addr;
    logic [1:0]  w_load_stat;
    logic [33:0] w_load_res;
    logic [39:0] w_tx_word;
    logic [2:0]  w_tx_last;
    logic        w_timeout;
    logic        w_unused;

    assign w_rx_fire   = rx_valid_i && r_rx_ready;
    assign w_tx_fire   = r_tx_valid && tx_ready_i;
    assign w_req_fire  = r_dmi_req_valid && dmi_req_ready_i;
    assign w_resp_fire = dmi_resp_valid_i && r_dmi_resp_ready;
    assign w_cmd       = rx_data_i[7:5];
    assign w_addr      = rx_data_i[4:0];
    assign w_last      = (r_addr == ADDR_DMI) ? (r_cnt == 3'd5) : (r_cnt == 3'd3);
    assign w_stat_after_rx = (w_payload[16] || w_payload[17]) ? 2'b00 : r_dmistat;
    assign w_unused    = ^w_payload[47:41];

    function automatic logic [31:0] dtmcs_word(input logic [1:0] stat);
        return {17'b0, IDLE_HINT, stat, 6'd7, 4'd1};
    endfunction

    // Payload word as it will look once the byte currently on rx_data_i lands.
    always_comb begin
        w_payload = {7'b0, r_payload};
        w_payload[{r_cnt, 3'b000} +: 8] = rx_data_i;
    end

    // Read-back word, computed from the values that hold after this cycle's update.
    always_comb begin
        w_load_addr = (r_state == StCmd) ? w_addr : r_addr;
        w_load_stat = (r_state == StRx) ? w_stat_after_rx : r_dmistat;
        w_load_res  = (r_state == StWait) ? dmi_resp_i : r_result;
        if (w_load_addr == ADDR_IDCODE) begin
            w_tx_word = {8'h00, IDCODE};
        end else if (w_load_addr == ADDR_DTMCS) begin
            w_tx_word = {8'h00, dtmcs_word(w_load_stat)};
        end else begin
            w_tx_word = {6'b0, w_load_res};
        end
        w_tx_last = (w_load_addr == ADDR_DMI) ? 3'd4 : 3'd3;
    end

`ifdef UART_DTM_TIMEOUT_EN
    logic [31:0] r_tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_rx_fire || !(r_state == StCmd || r_state == StRx)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end

    assign w_timeout = (r_tmo >= TIMEOUT_CYCLES - 1);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= StIdle;
            r_rw             <= 1'b0;
            r_addr           <= '0;
            r_payload        <= '0;
            r_cnt            <= '0;
            r_dmistat        <= '0;
            r_result         <= '0;
            r_tx_shift       <= '0;
            r_tx_left        <= '0;
            r_rx_ready       <= 1'b0;
            r_tx_valid       <= 1'b0;
            r_dmi_req        <= '0;
            r_dmi_req_valid  <= 1'b0;
            r_dmi_resp_ready <= 1'b0;
            r_hardreset      <= 1'b0;
        end else begin
            r_hardreset <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_rx_ready <= 1'b1;
                    if (w_rx_fire && rx_data_i == 8'h01) r_state <= StCmd;
                end
                StCmd: begin
                    if (w_rx_fire) begin
                        r_rw   <= (w_cmd == CMD_RW);
                        r_addr <= w_addr;
                        r_cnt  <= '0;
                        r_state <= StIdle;
                        if (w_cmd == CMD_RESET) begin
                            r_hardreset <= 1'b1;
                            r_dmistat   <= '0;
                            r_result    <= '0;
                        end else if (w_cmd == CMD_READ && (w_addr == ADDR_IDCODE ||
                                     w_addr == ADDR_DTMCS || w_addr == ADDR_DMI)) begin
                            r_tx_shift <= w_tx_word;
                            r_tx_left  <= w_tx_last;
                            r_tx_valid <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_state    <= StTx;
                        end else if ((w_cmd == CMD_WRITE || w_cmd == CMD_RW) &&
                                     (w_addr == ADDR_DTMCS || w_addr == ADDR_DMI)) begin
                            r_state <= StRx;
                        end
                    end else if (w_timeout) begin
                        r_state <= StIdle;
                    end
                end
                StRx: begin
                    if (w_rx_fire) begin
                        r_payload <= w_payload[40:0];
                        r_cnt     <= r_cnt + 3'd1;
                        if (w_last) begin
                            if (r_addr == ADDR_DTMCS) begin
                                r_dmistat <= w_stat_after_rx;
                                if (w_payload[17]) begin
                                    r_hardreset <= 1'b1;
                                    r_result    <= '0;
                                end
                            end
                            if (r_addr == ADDR_DMI && r_dmistat == 2'b00) begin
                                r_dmi_req       <= w_payload[40:0];
                                r_dmi_req_valid <= 1'b1;
                                r_rx_ready      <= 1'b0;
                                r_state         <= StReq;
                            end else if (r_rw) begin
                                r_tx_shift <= w_tx_word;
                                r_tx_left  <= w_tx_last;
                                r_tx_valid <= 1'b1;
                                r_rx_ready <= 1'b0;
                                r_state    <= StTx;
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= StIdle;
                    end
                end
                StReq: begin
                    if (w_req_fire) begin
                        r_dmi_req_valid  <= 1'b0;
                        r_dmi_resp_ready <= 1'b1;
                        r_state          <= StWait;
                    end
                end
                StWait: begin
                    if (w_resp_fire) begin
                        r_dmi_resp_ready <= 1'b0;
                        r_result         <= dmi_resp_i;
                        // First error wins; later errors leave dmistat untouched.
                        if (dmi_resp_i[1] && r_dmistat == 2'b00) r_dmistat <= dmi_resp_i[1:0];
                        if (r_rw) begin
                            r_tx_shift <= w_tx_word;
                            r_tx_left  <= w_tx_last;
                            r_tx_valid <= 1'b1;
                            r_state    <= StTx;
                        end else begin
                            r_rx_ready <= 1'b1;
                            r_state    <= StIdle;
                        end
                    end
                end
                StTx: begin
                    if (w_tx_fire) begin
                        if (r_tx_left == 3'd0) begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= StIdle;
                        end else begin
                            r_tx_shift <= {8'h00, r_tx_shift[39:8]};
                            r_tx_left  <= r_tx_left - 3'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rx_ready_o       = r_rx_ready;
    assign tx_data_o        = r_tx_shift[7:0];
    assign tx_valid_o       = r_tx_valid;
    assign dmi_req_o        = r_dmi_req;
    assign dmi_req_valid_o  = r_dmi_req_valid;
    assign dmi_resp_ready_o = r_dmi_resp_ready;
    assign dmi_hardreset_o  = r_hardreset;

endmodule

// File: tb/tb_uart_dtm_ctrl.sv
// Self-checking bench for uart_dtm_ctrl: directed frames plus randomized frames against a
// frame-level reference model; random back-pressure on TX and DMI handshakes.
module tb_uart_dtm_ctrl;

    localparam logic [4:0] A_ID    = 5'h01;
    localparam logic [4:0] A_DTMCS = 5'h10;
    localparam logic [4:0] A_DMI   = 5'h11;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [40:0] dmi_req;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [33:0] dmi_resp;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic        dmi_hardreset;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [40:0] req_q[$];
    logic [7:0]  exp_tx[$];
    logic [40:0] exp_req[$];
    int          exp_hr;
    int          hr_cycles = 0;
    int          hr_pulses = 0;
    logic        hr_prev = 1'b0;
    int          hr_c0, hr_p0;
    logic [33:0] resp_val;
    bit          tx_hold;

    // Reference model state
    logic [1:0]  m_stat;
    logic [33:0] m_res;

    logic [2:0]  rnd_cmd;
    logic [4:0]  rnd_addr;
    logic [47:0] rnd_pl;
    logic [33:0] rnd_rsp;
    int          rnd_sel;

    uart_dtm_ctrl #(
        .IDCODE(32'h00000001),
        .IDLE_HINT(3'd1),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .dmi_req_o(dmi_req),
        .dmi_req_valid_o(dmi_req_valid),
        .dmi_req_ready_i(dmi_req_ready),
        .dmi_resp_i(dmi_resp),
        .dmi_resp_valid_i(dmi_resp_valid),
        .dmi_resp_ready_o(dmi_resp_ready),
        .dmi_hardreset_o(dmi_hardreset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dmi_hardreset) hr_cycles <= hr_cycles + 1;
        if (dmi_hardreset && !hr_prev) hr_pulses <= hr_pulses + 1;
        hr_prev <= dmi_hardreset;
    end

    // TX sink: ready chosen per cycle; a byte is taken when valid and ready meet at the edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        end
    end

    // DMI responder: accepts a request, then answers with resp_val after a random delay.
    initial begin
        int n;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp       = '0;
        forever begin
            @(negedge clk);
            dmi_req_ready = ($urandom_range(0, 3) != 0);
            if (dmi_req_valid && dmi_req_ready) begin
                req_q.push_back(dmi_req);
                @(negedge clk);
                dmi_req_ready = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                dmi_resp       = resp_val;
                dmi_resp_valid = 1'b1;
                n = 0;
                while (!dmi_resp_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) check("resp_ready_wait", 64'(dmi_resp_ready), 64'd1);
                @(negedge clk);
                dmi_resp_valid = 1'b0;
                dmi_resp       = '0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic begin_frames();
        exp_tx.delete();
        exp_req.delete();
        exp_hr = 0;
        tx_q.delete();
        req_q.delete();
        hr_c0 = hr_cycles;
        hr_p0 = hr_pulses;
    endtask

    // Frame-level model: what a whole frame does to dmistat/result and what it emits.
    task automatic model_frame(input logic [2:0] cmd, input logic [4:0] addr,
                               input logic [47:0] pl, input logic [33:0] resp);
        bit known    = (addr == A_ID || addr == A_DTMCS || addr == A_DMI);
        bit writable = (addr == A_DTMCS || addr == A_DMI);
        bit do_write = (cmd == 3'd2 || cmd == 3'd3) && writable;
        bit do_read  = (cmd == 3'd1 && known) || (cmd == 3'd3 && writable);
        logic [39:0] word;
        int nbytes;
        if (cmd == 3'd4) begin
            exp_hr += 1;
            m_stat = 2'd0;
            m_res  = '0;
        end
        if (do_write && addr == A_DTMCS) begin
            if (pl[16] || pl[17]) m_stat = 2'd0;
            if (pl[17]) begin
                exp_hr += 1;
                m_res = '0;
            end
        end
        if (do_write && addr == A_DMI && m_stat == 2'd0) begin
            exp_req.push_back(pl[40:0]);
            m_res = resp;
            if (resp[1:0] >= 2'd2) m_stat = resp[1:0];
        end
        if (do_read) begin
            if (addr == A_ID) begin
                word = 40'd1;
                nbytes = 4;
            end else if (addr == A_DTMCS) begin
                word = 40'd1 + (40'd7 << 4) + (40'(m_stat) << 10) + (40'd1 << 12);
                nbytes = 4;
            end else begin
                word = 40'(m_res);
                nbytes = 5;
            end
            for (int i = 0; i < nbytes; i++) exp_tx.push_back(8'((word >> (8 * i)) & 40'hff));
        end
    endtask

    task automatic send_frame(input logic [2:0] cmd, input logic [4:0] addr,
                              input logic [47:0] pl, input bit junk);
        int n = 0;
        if (junk) send_byte(8'($urandom_range(2, 255)));
        send_byte(8'h01);
        send_byte({cmd, addr});
        if ((cmd == 3'd2 || cmd == 3'd3) && (addr == A_DTMCS || addr == A_DMI)) begin
            n = (addr == A_DMI) ? 6 : 4;
            for (int i = 0; i < n; i++) send_byte(pl[8 * i +: 8]);
        end
    endtask

    task automatic end_frames(input string tag);
        int n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(rx_ready), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 64'(tx_q[i]), 64'(exp_tx[i]));
        check({tag, "_req_count"}, 64'(req_q.size()), 64'(exp_req.size()));
        for (int i = 0; i < req_q.size() && i < exp_req.size(); i++)
            check({tag, "_req"}, 64'(req_q[i]), 64'(exp_req[i]));
        check({tag, "_hr_cycles"}, 64'(hr_cycles - hr_c0), 64'(exp_hr));
        check({tag, "_hr_pulses"}, 64'(hr_pulses - hr_p0), 64'(exp_hr));
    endtask

    task automatic run_frame(input string tag, input logic [2:0] cmd, input logic [4:0] addr,
                             input logic [47:0] pl, input logic [33:0] resp, input bit junk);
        resp_val = resp;
        begin_frames();
        model_frame(cmd, addr, pl, resp);
        send_frame(cmd, addr, pl, junk);
        end_frames(tag);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_hold  = 1'b0;
        resp_val = '0;
        m_stat   = 2'd0;
        m_res    = '0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_req", 64'(dmi_req), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        check("rst_hardreset", 64'(dmi_hardreset), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", 64'(rx_ready), 64'd1);

        run_frame("idcode", 3'd1, A_ID, '0, '0, 1'b0);
        run_frame("dtmcs_rd", 3'd1, A_DTMCS, '0, '0, 1'b0);
        run_frame("dmi_rw", 3'd3, A_DMI, {7'h00, 7'h10, 32'h00000001, 2'd2},
                  {32'hDEADBEEF, 2'd0}, 1'b0);

        // Sticky error, dropped request, then dmireset re-enables DMI.
        run_frame("dmi_err", 3'd2, A_DMI, 48'h0123_4567_89A9, {32'h0BADF00D, 2'd3}, 1'b0);
        run_frame("dmi_drop", 3'd2, A_DMI, 48'h0000_1111_2222, {32'h12345678, 2'd0}, 1'b0);
        run_frame("stat_rd", 3'd1, A_DTMCS, '0, '0, 1'b0);
        run_frame("dmireset", 3'd2, A_DTMCS, 48'h0000_0001_0000, '0, 1'b0);
        run_frame("stat_rd2", 3'd1, A_DTMCS, '0, '0, 1'b0);
        run_frame("dmi_again", 3'd3, A_DMI, 48'h0000_3333_4445, {32'hCAFEF00D, 2'd0}, 1'b1);

        run_frame("reset_cmd", 3'd4, 5'h00, '0, '0, 1'b0);
        run_frame("dmi_after_rst", 3'd2, A_DMI, 48'h0000_5555_6666, {32'h0000ABCD, 2'd2}, 1'b0);
        run_frame("hardreset", 3'd2, A_DTMCS, 48'h0000_0002_0000, '0, 1'b0);
        run_frame("result_rd", 3'd1, A_DMI, '0, '0, 1'b0);
        run_frame("wr_idcode", 3'd2, A_ID, '0, '0, 1'b0);

        // Second frame is back-pressured while the first is still transmitting.
        begin_frames();
        model_frame(3'd1, A_ID, '0, '0);
        send_frame(3'd1, A_ID, '0, 1'b0);
        model_frame(3'd1, A_DTMCS, '0, '0);
        send_frame(3'd1, A_DTMCS, '0, 1'b0);
        end_frames("b2b");

        // Reset while a read is stalled in TX.
        tx_hold = 1'b1;
        begin_frames();
        send_frame(3'd1, A_ID, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("tx_before_rst", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        rst     = 1'b0;
        tx_hold = 1'b0;
        m_stat  = 2'd0;
        m_res   = '0;
        repeat (4) @(negedge clk);
        check("midrst_no_tx", 64'(tx_q.size()), 64'd0);
        check("midrst_idle", 64'(rx_ready), 64'd1);

        for (int k = 0; k < 80; k++) begin
            rnd_sel = $urandom_range(0, 9);
            if (rnd_sel == 0) rnd_cmd = 3'd0;
            else if (rnd_sel <= 3) rnd_cmd = 3'd1;
            else if (rnd_sel <= 5) rnd_cmd = 3'd2;
            else if (rnd_sel <= 7) rnd_cmd = 3'd3;
            else if (rnd_sel == 8) rnd_cmd = 3'd4;
            else rnd_cmd = 3'($urandom_range(5, 7));
            rnd_sel = $urandom_range(0, 9);
            if (rnd_sel <= 2) rnd_addr = A_ID;
            else if (rnd_sel <= 5) rnd_addr = A_DTMCS;
            else if (rnd_sel <= 8) rnd_addr = A_DMI;
            else rnd_addr = 5'($urandom);
            rnd_pl = {16'($urandom), 32'($urandom)};
            rnd_pl[17:16] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rnd_rsp = {32'($urandom), 2'd0};
            if ($urandom_range(0, 4) == 0) rnd_rsp[1:0] = 2'($urandom_range(1, 3));
            run_frame($sformatf("rnd%0d", k), rnd_cmd, rnd_addr, rnd_pl, rnd_rsp,
                      ($urandom_range(0, 4) == 0));
        end

`ifdef UART_DTM_TIMEOUT_EN
        begin_frames();
        send_byte(8'h01);
        send_byte(8'h51);
        send_byte(8'h02);
        repeat (60) @(negedge clk);
        model_frame(3'd1, A_ID, '0, '0);
        send_frame(3'd1, A_ID, '0, 1'b0);
        end_frames("timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
